// File: rtl/res4bit_div_ctrl.sv
//------------------------------------------------------------------------------
// Module      : res4bit_div_ctrl
// Description : Sequencer for restoring unsigned division
//               (dividend / divisor -> quotient, remainder). Each clock it
//               drives one step of an external WIDTH-bit subtractor
//               (result = a - b, carry out = no borrow) that lives in the parent.
// Macro       : DIV_BY_ZERO_CHECK_EN - when defined, a zero divisor skips the
//               iteration phase and raises div_by_zero together with done.
// Ports       : clk, rst          - clock (rising edge), sync active-high reset
//               start             - request, accepted only in IDLE
//               dividend, divisor - operands, sampled on the accept edge
//               sub_a, sub_b      - subtractor operands (sub_b = latched divisor)
//               sub_result, sub_co- subtractor difference and no-borrow flag
//               busy, done        - operation in flight / one-cycle result strobe
//               quotient, remainder - results, held until the next result
//               div_by_zero       - zero-divisor flag (constant 0 without macro)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module res4bit_div_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_result,
  input  logic             sub_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  // Partial remainder shifted left with the next dividend bit brought in.
  // After WIDTH-1 steps R < 2^(WIDTH-1), so the shift never loses a bit.
  assign w_shifted = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  // Restore step: keep the difference only when the subtraction did not borrow.
  assign w_r_next  = sub_co ? sub_result : w_shifted;
  assign w_q_next  = {r_q[WIDTH-2:0], sub_co};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  assign sub_a     = (r_state == S_ITER) ? w_shifted : '0;
  assign sub_b     = r_d;

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_rem;

`ifdef DIV_BY_ZERO_CHECK_EN
  logic r_dz;
  logic r_dbz;
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
`ifdef DIV_BY_ZERO_CHECK_EN
      r_dz    <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q     <= dividend;
            r_r     <= '0;
            r_d     <= divisor;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ITER;
`ifdef DIV_BY_ZERO_CHECK_EN
            r_dz    <= (divisor == '0);
            r_dbz   <= 1'b0;
`endif
          end
        end

        S_ITER: begin
`ifdef DIV_BY_ZERO_CHECK_EN
          // Zero divisor: spend a single cycle here, then report the
          // same quotient/remainder the full iteration would produce.
          if (r_dz) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= '1;
            r_rem   <= r_q;
            r_dbz   <= 1'b1;
          end else
`endif
          begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_quot  <= w_q_next;
              r_rem   <= w_r_next;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_res4bit_div_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_res4bit_div_ctrl
// Description : Self-checking bench for res4bit_div_ctrl with an inline
//               subtractor (result = a - b, carry out = a >= b).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_res4bit_div_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] sub_a;
  logic [W-1:0] sub_b;
  logic [W-1:0] sub_result;
  logic         sub_co;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Subtractor behaviour seen by the controller
  assign sub_result = sub_a - sub_b;
  assign sub_co     = (sub_a >= sub_b);

  res4bit_div_ctrl #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_result (sub_result),
    .sub_co     (sub_co),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definition
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Advance until done is seen high (at least one edge), bounded.
  task automatic wait_done(output int t);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done && n < 30);
    chk("done_timeout", int'(done), 1);
    t = cyc;
  endtask

  // One operation from IDLE; optionally scrambles the inputs while busy.
  task automatic do_op(input int a, input int b, input bit scramble);
    int lat, bcnt, elat, edz;
    elat = W;
    edz  = 0;
`ifdef DIV_BY_ZERO_CHECK_EN
    if (b == 0) begin
      elat = 1;
      edz  = 1;
    end
`endif
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dbz_after_accept", int'(div_by_zero), 0);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      if (scramble) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
        start    = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("busy_cycles", bcnt, elat);
    chk("quotient", int'(quotient), ref_q(a, b));
    chk("remainder", int'(remainder), ref_r(a, b));
    chk("div_by_zero", int'(div_by_zero), edz);
    chk("busy_at_done", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_width", int'(done), 0);
  endtask

  // start held high across two operations; the second is taken only after
  // the controller returns to IDLE.
  task automatic held_pair(input int a1, input int b1, input int a2, input int b2);
    int t1, t2;
    dividend = W'(a1);
    divisor  = W'(b1);
    start    = 1'b1;
    @(posedge clk); #1;
    dividend = W'(a2);
    divisor  = W'(b2);
    wait_done(t1);
    chk("held_q1", int'(quotient), ref_q(a1, b1));
    chk("held_r1", int'(remainder), ref_r(a1, b1));
    wait_done(t2);
    start = 1'b0;
    chk("held_q2", int'(quotient), ref_q(a2, b2));
    chk("held_r2", int'(remainder), ref_r(a2, b2));
    chk("done_spacing", t2 - t1, W + 2);
    @(posedge clk); #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    chk("rst_sub_a", int'(sub_a), 0);
    chk("rst_sub_b", int'(sub_b), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic case
    do_op(13, 3, 1'b0);

    // Full operand space with non-zero divisor
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        do_op(a, b, 1'b0);

    // Zero divisor
    do_op(9, 0, 1'b0);

    // Held start with inputs changed mid-run, and back-to-back spacing
    held_pair(13, 3, 2, 2);
    held_pair(6, 4, 15, 2);

    // Reset in the middle of an operation
    dividend = 4'd14;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_sub_a", int'(sub_a), 0);
    do_op(14, 5, 1'b0);

    // Randomized operations with inputs toggling while busy
    for (int i = 0; i < 80; i++)
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
